// File: rtl/arbitro_pkg.sv
// Shared encodings for the X/Y datapath arbiter: FSM states and mux selector codes.
// State codes equal the selector codes so the selector is a direct copy of the next state.
package arbitro_pkg;

   localparam logic [1:0] SEL_X    = 2'b00;
   localparam logic [1:0] SEL_Y    = 2'b01;
   localparam logic [1:0] SEL_IDLE = 2'b10;

   typedef enum logic [1:0] {
      ST_OWN_X = SEL_X,
      ST_OWN_Y = SEL_Y,
      ST_IDLE  = SEL_IDLE
   } state_t;

endpackage

// File: rtl/mux2a1_reg.sv
// Registered 2-to-1 mux: loads the side chosen by sel, holds its value when sel is idle.
module mux2a1_reg
   import arbitro_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else begin
         case (sel)
            SEL_X:   q <= d0;
            SEL_Y:   q <= d1;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/arbitro_mux2a1.sv
// Round-robin arbiter with burst limit sharing a registered 2-to-1 mux between requesters X and Y.
// Define ARB_FIXED_PRIO_EN for fixed priority (X wins ties, owner keeps the datapath until it drops req).
module arbitro_mux2a1
   import arbitro_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_x,
   input  logic             req_y,
   input  logic [WIDTH-1:0] data_x,
   input  logic [WIDTH-1:0] data_y,
   output logic             gnt_x,
   output logic             gnt_y,
   output logic [1:0]       selector,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out
);

   state_t state, state_nxt;

`ifndef ARB_FIXED_PRIO_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             last_y, last_y_nxt;   // last owner was Y; X wins the next tie
`endif

   // Next-state logic
   always_comb begin
      state_nxt = state;
`ifndef ARB_FIXED_PRIO_EN
      cnt_nxt    = cnt;
      last_y_nxt = last_y;
      case (state)
         ST_IDLE: begin
            if (req_x && req_y) state_nxt = last_y ? ST_OWN_X : ST_OWN_Y;
            else if (req_x)     state_nxt = ST_OWN_X;
            else if (req_y)     state_nxt = ST_OWN_Y;
         end
         ST_OWN_X: begin
            if (!req_x)                        state_nxt = req_y ? ST_OWN_Y : ST_IDLE;
            else if (req_y && cnt == CNT_LAST) state_nxt = ST_OWN_Y;
            else if (cnt != CNT_LAST)          cnt_nxt   = cnt + CNT_W'(1);
         end
         ST_OWN_Y: begin
            if (!req_y)                        state_nxt = req_x ? ST_OWN_X : ST_IDLE;
            else if (req_x && cnt == CNT_LAST) state_nxt = ST_OWN_X;
            else if (cnt != CNT_LAST)          cnt_nxt   = cnt + CNT_W'(1);
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (state_nxt != state) begin
         cnt_nxt = '0;
         if (state_nxt == ST_OWN_X) last_y_nxt = 1'b0;
         if (state_nxt == ST_OWN_Y) last_y_nxt = 1'b1;
      end
`else
      case (state)
         ST_IDLE: begin
            if (req_x)      state_nxt = ST_OWN_X;
            else if (req_y) state_nxt = ST_OWN_Y;
         end
         ST_OWN_X: if (!req_x) state_nxt = req_y ? ST_OWN_Y : ST_IDLE;
         ST_OWN_Y: if (!req_y) state_nxt = req_x ? ST_OWN_X : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
`endif
   end

   // State, grant and selector registers; grants and selector mirror the registered state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         gnt_x     <= 1'b0;
         gnt_y     <= 1'b0;
         selector  <= SEL_IDLE;
         valid_out <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         cnt       <= '0;
         last_y    <= 1'b1;
`endif
      end else begin
         state     <= state_nxt;
         gnt_x     <= (state_nxt == ST_OWN_X);
         gnt_y     <= (state_nxt == ST_OWN_Y);
         selector  <= 2'(state_nxt);
         valid_out <= (gnt_x & req_x) | (gnt_y & req_y);
`ifndef ARB_FIXED_PRIO_EN
         cnt       <= cnt_nxt;
         last_y    <= last_y_nxt;
`endif
      end
   end

   mux2a1_reg #(
      .WIDTH (WIDTH)
   ) u_data_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .sel   (selector),
      .d0    (data_x),
      .d1    (data_y),
      .q     (data_out)
   );

endmodule

// File: tb/tb_arbitro_mux2a1.sv
// Self-checking bench for arbitro_mux2a1: directed scenarios plus random traffic against an ownership/run-length model.
module tb_arbitro_mux2a1;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned MAX_BURST = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_x, req_y;
   logic [WIDTH-1:0] data_x, data_y;
   logic             gnt_x, gnt_y, valid_out;
   logic [1:0]       selector;
   logic [WIDTH-1:0] data_out;

   int checks = 0;
   int errors = 0;

   // Model: owner 0=none 1=X 2=Y; run = cycles granted in current ownership
   int               m_owner, m_run, m_last;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;

   always #5 clk = ~clk;

   arbitro_mux2a1 #(
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST),
      .CNT_W     (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_x     (req_x),
      .req_y     (req_y),
      .data_x    (data_x),
      .data_y    (data_y),
      .gnt_x     (gnt_x),
      .gnt_y     (gnt_y),
      .selector  (selector),
      .data_out  (data_out),
      .valid_out (valid_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_run   = 0;
      m_last  = 2;
      m_valid = 1'b0;
      m_data  = '0;
   endtask

   // Apply one rising edge to the model using the inputs presented during the past cycle
   task automatic model_edge();
      int nxt;
      m_valid = (m_owner == 1 && req_x) || (m_owner == 2 && req_y);
      if (m_owner == 1) m_data = data_x;
      else if (m_owner == 2) m_data = data_y;
`ifdef ARB_FIXED_PRIO_EN
      case (m_owner)
         1:       nxt = req_x ? 1 : (req_y ? 2 : 0);
         2:       nxt = req_y ? 2 : (req_x ? 1 : 0);
         default: nxt = req_x ? 1 : (req_y ? 2 : 0);
      endcase
`else
      case (m_owner)
         1: begin
            if (!req_x)                          nxt = req_y ? 2 : 0;
            else if (req_y && m_run >= MAX_BURST) nxt = 2;
            else                                 nxt = 1;
         end
         2: begin
            if (!req_y)                          nxt = req_x ? 1 : 0;
            else if (req_x && m_run >= MAX_BURST) nxt = 1;
            else                                 nxt = 2;
         end
         default: begin
            if (req_x && req_y) nxt = (m_last == 1) ? 2 : 1;
            else if (req_x)     nxt = 1;
            else if (req_y)     nxt = 2;
            else                nxt = 0;
         end
      endcase
`endif
      if (nxt != 0 && nxt == m_owner) m_run++;
      else if (nxt != 0)              m_run = 1;
      else                            m_run = 0;
      if (nxt != 0) m_last = nxt;
      m_owner = nxt;
   endtask

   task automatic check_all(input string where);
      chk({where, ".gnt_x"}, 32'(gnt_x), 32'(m_owner == 1));
      chk({where, ".gnt_y"}, 32'(gnt_y), 32'(m_owner == 2));
      chk({where, ".selector"}, 32'(selector),
          (m_owner == 1) ? 32'd0 : (m_owner == 2) ? 32'd1 : 32'd2);
      chk({where, ".valid_out"}, 32'(valid_out), 32'(m_valid));
      chk({where, ".data_out"}, 32'(data_out), 32'(m_data));
      chk({where, ".one_hot"}, 32'(gnt_x & gnt_y), 32'd0);
   endtask

   task automatic step(input string where);
      @(posedge clk);
      model_edge();
      #1;
      check_all(where);
   endtask

   task automatic drive(input logic rx, input logic ry);
      req_x  = rx;
      req_y  = ry;
      data_x = WIDTH'($urandom);
      data_y = WIDTH'($urandom);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b1, 1'b0);
      model_reset();

      // Reset held with X requesting: outputs stay at reset values
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_all("reset_hold");
      end
      rst_n = 1'b1;
      step("reset_release");

      // Single requester X with a fixed payload
      req_x = 1'b1; req_y = 1'b0; data_x = 8'hA5;
      for (int i = 0; i < 3; i++) step("single_x");
      drive(1'b0, 1'b0);
      step("single_x_drop");
      step("idle");

      // Continuous contention: bursts alternate without idle gaps
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, 1'b1);
         step("contention");
      end
      drive(1'b0, 1'b0);
      step("contention_end");
      step("idle2");

      // Early release: X owns, Y starts requesting, X drops after its second beat
      drive(1'b1, 1'b0);
      step("early_own_x");
      drive(1'b1, 1'b1);
      step("early_both");
      drive(1'b0, 1'b1);
      step("early_handoff");
      drive(1'b0, 1'b1);
      step("early_y_beat");
      drive(1'b0, 1'b0);
      step("early_end");

      // Random traffic, biased toward contention
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
         step("random");
      end

      // Reset mid-burst while Y owns
      drive(1'b0, 1'b0);
      step("pre_y_idle");
      step("pre_y_idle2");
      drive(1'b0, 1'b1);
      step("own_y");
      step("own_y2");
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all("reset_async");
      drive(1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      step("after_reset_tie");
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1);
         step("after_reset_both");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
